// File: rtl/comp_seq_arb.sv
// comp_seq_arb: round-robin arbiter and nibble-serial sequencer for the
// shared 4-bit equality comparator (comp2_1x_4), LSB nibble first.
// Ports: clk, reset (sync, active-high); req0/req1 valid/ready/a/b
// request channels; cmp_a/cmp_b/cmp_status comparator drive; rsp_valid,
// rsp_ready, rsp_eq, rsp_id response channel.
// Option: COMP_SEQ_ARB_MISMATCH_IDX_EN adds rsp_nib (first mismatching
// nibble index, NIB when equal).
module comp_seq_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_eq,
  output logic             rsp_id
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
  ,
  output logic [$clog2(WIDTH/4+1)-1:0] rsp_nib
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    RESP
  } state_t;

  state_t           state;
  logic             ptr;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             eq_q;
  logic             id_q;
  logic             gnt0;
  logic             gnt1;

`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
  localparam int NW = $clog2(NIB + 1);
  logic [NW-1:0] nib_q;
`endif

  // Grant only from IDLE; on contention the pointer decides.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !reset) begin
      gnt0 = req0_valid & (~req1_valid | ~ptr);
      gnt1 = req1_valid & (~req0_valid | ptr);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Operands shift right one nibble per compare step, so the
  // current nibble always sits in bits [3:0].
  always_comb begin
    cmp_a = 4'h0;
    cmp_b = 4'h0;
    if (state == COMPARE && !reset) begin
      cmp_a = a_q[3:0];
      cmp_b = b_q[3:0];
    end
  end

  // Outputs read as zero while reset is held, whatever the state.
  assign rsp_valid = (state == RESP) & ~reset;
  assign rsp_eq    = eq_q & ~reset;
  assign rsp_id    = id_q & ~reset;

`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
  assign rsp_nib = reset ? '0 : nib_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      eq_q  <= 1'b0;
      id_q  <= 1'b0;
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
      nib_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            a_q   <= gnt1 ? req1_a : req0_a;
            b_q   <= gnt1 ? req1_b : req0_b;
            id_q  <= gnt1;
            idx   <= '0;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (!cmp_status) begin
            eq_q  <= 1'b0;
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
            nib_q <= NW'(idx);
`endif
            state <= RESP;
          end else if (idx == LAST) begin
            eq_q  <= 1'b1;
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
            nib_q <= NW'(NIB);
`endif
            state <= RESP;
          end else begin
            idx <= idx + IW'(1);
            a_q <= a_q >> 4;
            b_q <= b_q >> 4;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ptr   <= ~id_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_seq_arb.sv
// tb_comp_seq_arb: directed self-checking bench for comp_seq_arb
// (WIDTH = 16) with a behavioural 4-bit equality comparator.
module tb_comp_seq_arb;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic [3:0]  cmp_a, cmp_b;
  logic        cmp_status;
  logic        rsp_valid, rsp_ready, rsp_eq, rsp_id;
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
  logic [2:0]  rsp_nib;
`endif

  int tests;
  int fails;

  comp_seq_arb #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_status (cmp_status),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_eq     (rsp_eq),
    .rsp_id     (rsp_id)
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
    ,
    .rsp_nib    (rsp_nib)
`endif
  );

  assign cmp_status = (cmp_a == cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    #1;
    tests++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id, cmp_a, cmp_b}
        !== 13'h0) begin
      fails++;
      $display("FAIL reset_hold outputs got %b exp 0",
        {req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id, cmp_a, cmp_b});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    tests++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id, cmp_a, cmp_b}
        !== 13'h0) begin
      fails++;
      $display("FAIL reset_idle outputs got %b exp 0",
        {req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id, cmp_a, cmp_b});
    end
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
    tests++;
    if (rsp_nib !== 3'd0) begin
      fails++;
      $display("FAIL reset_nib got %0d exp 0", rsp_nib);
    end
`endif
  endtask

  task automatic test_equal();
    logic [3:0] exp_nib [4];
    exp_nib[0] = 4'h3;
    exp_nib[1] = 4'hC;
    exp_nib[2] = 4'h5;
    exp_nib[3] = 4'hA;
    do_reset();
    req0_valid = 1'b1;
    req0_a = 16'hA5C3;
    req0_b = 16'hA5C3;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL eq_grant got %b exp 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (cmp_a !== exp_nib[i] || cmp_b !== exp_nib[i] || rsp_valid) begin
        fails++;
        $display("FAIL eq_nib%0d got a=%h b=%h v=%b exp %h v=0",
          i, cmp_a, cmp_b, rsp_valid, exp_nib[i]);
      end
      step();
    end
    #1;
    tests++;
    if ({rsp_valid, rsp_eq, rsp_id} !== 3'b110) begin
      fails++;
      $display("FAIL eq_rsp got %b exp 110", {rsp_valid, rsp_eq, rsp_id});
    end
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
    tests++;
    if (rsp_nib !== 3'd4) begin
      fails++;
      $display("FAIL eq_nib got %0d exp 4", rsp_nib);
    end
`endif
    step();
    #1;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL eq_done rsp_valid got %b exp 0", rsp_valid);
    end
  endtask

  task automatic test_lsb_mismatch();
    do_reset();
    req1_valid = 1'b1;
    req1_a = 16'h1234;
    req1_b = 16'h1235;
    rsp_ready = 1'b1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      fails++;
      $display("FAIL lsb_grant got %b exp 01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    #1;
    tests++;
    if (cmp_a !== 4'h4 || cmp_b !== 4'h5 || rsp_valid) begin
      fails++;
      $display("FAIL lsb_cmp got a=%h b=%h v=%b exp a=4 b=5 v=0",
        cmp_a, cmp_b, rsp_valid);
    end
    step();
    #1;
    tests++;
    if ({rsp_valid, rsp_eq, rsp_id} !== 3'b101) begin
      fails++;
      $display("FAIL lsb_rsp got %b exp 101", {rsp_valid, rsp_eq, rsp_id});
    end
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
    tests++;
    if (rsp_nib !== 3'd0) begin
      fails++;
      $display("FAIL lsb_nib got %0d exp 0", rsp_nib);
    end
`endif
    step();
  endtask

  // Operands are changed after accept to show they were latched.
  task automatic test_msb_mismatch();
    int cyc;
    do_reset();
    req0_valid = 1'b1;
    req0_a = 16'h0000;
    req0_b = 16'h8000;
    rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    req0_a = 16'h8000;
    cyc = 0;
    while (cyc < 10) begin
      #1;
      if (rsp_valid) break;
      cyc++;
      step();
    end
    tests++;
    if (cyc !== 4) begin
      fails++;
      $display("FAIL msb_latency got %0d exp 4", cyc);
    end
    tests++;
    if ({rsp_valid, rsp_eq, rsp_id} !== 3'b100) begin
      fails++;
      $display("FAIL msb_rsp got %b exp 100", {rsp_valid, rsp_eq, rsp_id});
    end
`ifdef COMP_SEQ_ARB_MISMATCH_IDX_EN
    tests++;
    if (rsp_nib !== 3'd3) begin
      fails++;
      $display("FAIL msb_nib got %0d exp 3", rsp_nib);
    end
`endif
    step();
  endtask

  task automatic test_round_robin();
    int order [4];
    int ng;
    logic p0, p1;
    do_reset();
    req0_valid = 1'b1;
    req0_a = 16'h1111;
    req0_b = 16'h1111;
    req1_valid = 1'b1;
    req1_a = 16'h0001;
    req1_b = 16'h0000;
    rsp_ready = 1'b1;
    ng = 0;
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      tests++;
      if ((req0_ready && (req1_ready || p0)) || (req1_ready && p1)) begin
        fails++;
        $display("FAIL rr_pulse cyc%0d got r0=%b r1=%b prev=%b%b exp one",
          c, req0_ready, req1_ready, p0, p1);
      end
      if (req0_ready) begin
        order[ng] = 0;
        ng++;
      end else if (req1_ready) begin
        order[ng] = 1;
        ng++;
      end
      p0 = req0_ready;
      p1 = req1_ready;
      step();
    end
    tests++;
    if (ng !== 4) begin
      fails++;
      $display("FAIL rr_timeout grants got %0d exp 4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (order[i] !== (i % 2)) begin
          fails++;
          $display("FAIL rr_order%0d got %0d exp %0d", i, order[i], i % 2);
        end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1'b1;
    req0_a = 16'h00F0;
    req0_b = 16'h0070;
    req1_valid = 1'b1;
    req1_a = 16'h0000;
    req1_b = 16'h0000;
    rsp_ready = 1'b0;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL bp_grant got %b exp 10", {req0_ready, req1_ready});
    end
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
        fails++;
        $display("FAIL bp_cmp%0d got %b exp 000", i,
          {req0_ready, req1_ready, rsp_valid});
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id} !== 5'b00100)
      begin
        fails++;
        $display("FAIL bp_hold%0d got %b exp 00100", i,
          {req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id});
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if ({rsp_valid, rsp_eq, rsp_id} !== 3'b100) begin
      fails++;
      $display("FAIL bp_hs got %b exp 100", {rsp_valid, rsp_eq, rsp_id});
    end
    step();
    #1;
    tests++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      fails++;
      $display("FAIL bp_next got %b exp 001",
        {rsp_valid, req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    do_reset();
    req0_valid = 1'b1;
    req0_a = 16'h0000;
    req0_b = 16'h0000;
    rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    tests++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id, cmp_a, cmp_b}
        !== 13'h0) begin
      fails++;
      $display("FAIL mid_idle got %b exp 0",
        {req0_ready, req1_ready, rsp_valid, rsp_eq, rsp_id, cmp_a, cmp_b});
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      #1;
      if (rsp_valid || cmp_a != 4'h0) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL mid_abort activity got %0d exp 0", seen);
    end
    req1_valid = 1'b1;
    req1_a = 16'hABCD;
    req1_b = 16'hABCD;
    #1;
    tests++;
    if (req1_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_fresh_grant got %b exp 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    cyc = 0;
    while (cyc < 10) begin
      #1;
      if (rsp_valid) break;
      cyc++;
      step();
    end
    tests++;
    if (cyc !== 4 || {rsp_valid, rsp_eq, rsp_id} !== 3'b111) begin
      fails++;
      $display("FAIL mid_fresh_rsp got lat=%0d %b exp lat=4 111",
        cyc, {rsp_valid, rsp_eq, rsp_id});
    end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_equal();
    test_lsb_mismatch();
    test_msb_mismatch();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
